cpu_control: RTL and testbench

//  Microsequencer driving every load/inc/bus-enable strobe of the tiny-CPU datapath (ar, pc, dr, tr, ir,
//  r0-r3, x, y, z, alu, memory). Consumes ir opcode and z flag; steps fetch/decode/execute per clk_choose.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/cpu_ctl_decode.sv | 101 ++++++++++
 rtl/cpu_control.sv | 121 ++++++++++++
 tb/tb_cpu_control.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the tiny-CPU microsequencer: opcodes, ALU select codes,
// run-control encodings, sequencer states and the strobe bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_MOV = 4'h3,
                           OP_MVI = 4'h4, OP_ADD = 4'h5, OP_SUB = 4'h6, OP_AND = 4'h7,
                           OP_OR  = 4'h8, OP_NOT = 4'h9, OP_INC = 4'hA, OP_JMP = 4'hB,
                           OP_JZ  = 4'hC, OP_JNZ = 4'hD, OP_HLT = 4'hE;

    // PASS is zero so an idle alus bus reads as all-zero.
    localparam logic [3:0] ALUS_PASS = 4'h0, ALUS_ADD = 4'h1, ALUS_SUB = 4'h2, ALUS_AND = 4'h3,
                           ALUS_OR   = 4'h4, ALUS_NOT = 4'h5, ALUS_INC = 4'h6;

    localparam logic [1:0] CS_STOP = 2'b00, CS_RUN = 2'b01, CS_STEP = 2'b10, CS_CLEAR = 2'b11;

    typedef enum logic [4:0] {
        ST_IDLE, ST_F1, ST_F2, ST_F3, ST_DEC,
        ST_A1, ST_A2, ST_A3,
        ST_L1, ST_L2, ST_L3,
        ST_S1, ST_S2,
        ST_MV,
        ST_M1, ST_M2, ST_M3,
        ST_X1, ST_X2, ST_X3,
        ST_J1, ST_HALT
    } state_t;

    typedef struct packed {
        logic       arload, arinc, pcload, pcinc, drload, trload, irload;
        logic       xload, yload, zload;
        logic [3:0] rload;
        logic [3:0] rbus;
        logic       pcbus, drhbus, drlbus, trbus, ybus, membus, busmem;
        logic       read, write;
        logic [3:0] alus;
    } ctl_t;

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALUS_ADD;
            OP_SUB:  return ALUS_SUB;
            OP_AND:  return ALUS_AND;
            OP_OR:   return ALUS_OR;
            OP_NOT:  return ALUS_NOT;
            OP_INC:  return ALUS_INC;
            default: return ALUS_PASS;
        endcase
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/cpu_ctl_decode.sv
// Combinational strobe decode: current sequencer state plus ir (and z for the
// conditional jumps) -> full datapath strobe bundle.
module cpu_ctl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [7:0] ir,
    input  logic       z,
    output ctl_t       ctl
);

    logic [3:0] op;
    logic [3:0] rd_sel;
    logic [3:0] rs_sel;
    logic       taken;
    logic       unary;

    assign op     = ir[7:4];
    assign rd_sel = onehot4(ir[3:2]);
    assign rs_sel = onehot4(ir[1:0]);
    assign taken  = (op == OP_JMP) || ((op == OP_JZ) && z) || ((op == OP_JNZ) && !z);
    assign unary  = (op == OP_NOT) || (op == OP_INC);

    always_comb begin
        ctl = '0;
        case (state)
            ST_F1, ST_A1, ST_M1: begin
                ctl.pcbus  = 1'b1;
                ctl.arload = 1'b1;
            end
            ST_F2, ST_M2: begin
                ctl.read   = 1'b1;
                ctl.membus = 1'b1;
                ctl.drload = 1'b1;
                ctl.pcinc  = 1'b1;
            end
            ST_F3: ctl.irload = 1'b1;
            ST_A2: begin
                ctl.read   = 1'b1;
                ctl.membus = 1'b1;
                ctl.drload = 1'b1;
                ctl.pcinc  = 1'b1;
                ctl.arinc  = 1'b1;
            end
            // High address byte moves dr->tr while the low byte lands in dr.
            ST_A3: begin
                ctl.trload = 1'b1;
                ctl.read   = 1'b1;
                ctl.membus = 1'b1;
                ctl.drload = 1'b1;
                ctl.pcinc  = 1'b1;
            end
            ST_L1, ST_S1: begin
                ctl.drhbus = 1'b1;
                ctl.trbus  = 1'b1;
                ctl.arload = 1'b1;
            end
            ST_L2: begin
                ctl.read   = 1'b1;
                ctl.membus = 1'b1;
                ctl.drload = 1'b1;
            end
            ST_L3, ST_M3: begin
                ctl.drlbus = 1'b1;
                ctl.rload  = rd_sel;
            end
            ST_S2: begin
                ctl.rbus   = rs_sel;
                ctl.busmem = 1'b1;
                ctl.write  = 1'b1;
            end
            ST_MV: begin
                ctl.rbus  = rs_sel;
                ctl.rload = rd_sel;
            end
            ST_X1: begin
                ctl.rbus  = rd_sel;
                ctl.xload = 1'b1;
            end
            ST_X2: begin
                ctl.rbus  = unary ? rd_sel : rs_sel;
                ctl.alus  = alu_code(op);
                ctl.yload = 1'b1;
                ctl.zload = 1'b1;
            end
            ST_X3: begin
                ctl.ybus  = 1'b1;
                ctl.rload = rd_sel;
            end
            ST_J1: begin
                if (taken) begin
                    ctl.drhbus = 1'b1;
                    ctl.trbus  = 1'b1;
                    ctl.pcload = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Tiny-CPU microsequencer: holds the fetch/decode/execute state and gates the
// decoded strobes with the run-control input.
module cpu_control
    import cpu_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       z,
    input  logic [1:0] cpustate,
    output logic       arload, arinc, pcload, pcinc, drload, trload, irload,
    output logic       xload, yload, zload,
    output logic       r0load, r1load, r2load, r3load,
    output logic       r0bus, r1bus, r2bus, r3bus,
    output logic       pcbus, drhbus, drlbus, trbus, ybus, membus, busmem,
    output logic       read, write,
    output logic [3:0] alus,
    output logic       clr,
    output state_t     dbg_state
);

    state_t     state, state_nx;
    ctl_t       ctl, gated;
    logic       run;
    logic [3:0] op;

    assign op  = din[7:4];
    assign run = rst && ((cpustate == CS_RUN) || (cpustate == CS_STEP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cpustate == CS_CLEAR) begin
            state_nx = ST_IDLE;
        end else if (run) begin
            case (state)
                ST_IDLE: state_nx = ST_F1;
                ST_F1:   state_nx = ST_F2;
                ST_F2:   state_nx = ST_F3;
                ST_F3:   state_nx = ST_DEC;
                ST_DEC: begin
                    case (op)
                        OP_NOP:                                state_nx = ST_F1;
                        OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JNZ: state_nx = ST_A1;
                        OP_MOV:                                state_nx = ST_MV;
                        OP_MVI:                                state_nx = ST_M1;
                        OP_ADD, OP_SUB, OP_AND, OP_OR:         state_nx = ST_X1;
                        OP_NOT, OP_INC:                        state_nx = ST_X2;
                        OP_HLT:                                state_nx = ST_HALT;
                        default: state_nx = HALT_ON_UNDEF ? ST_HALT : ST_F1;
                    endcase
                end
                ST_A1: state_nx = ST_A2;
                ST_A2: state_nx = ST_A3;
                ST_A3: begin
                    if (op == OP_LDA)      state_nx = ST_L1;
                    else if (op == OP_STA) state_nx = ST_S1;
                    else                   state_nx = ST_J1;
                end
                ST_L1:   state_nx = ST_L2;
                ST_L2:   state_nx = ST_L3;
                ST_S1:   state_nx = ST_S2;
                ST_M1:   state_nx = ST_M2;
                ST_M2:   state_nx = ST_M3;
                ST_X1:   state_nx = ST_X2;
                ST_X2:   state_nx = ST_X3;
                ST_HALT: state_nx = ST_HALT;
                ST_L3, ST_S2, ST_MV, ST_M3, ST_X3, ST_J1: state_nx = ST_F1;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    cpu_ctl_decode u_decode (
        .state (state),
        .ir    (din),
        .z     (z),
        .ctl   (ctl)
    );

    // Stop and clear both silence every strobe; clear overrides everything.
    assign gated = run ? ctl : '0;
    assign clr   = rst && (cpustate == CS_CLEAR);

    assign arload = gated.arload;
    assign arinc  = gated.arinc;
    assign pcload = gated.pcload;
    assign pcinc  = gated.pcinc;
    assign drload = gated.drload;
    assign trload = gated.trload;
    assign irload = gated.irload;
    assign xload  = gated.xload;
    assign yload  = gated.yload;
    assign zload  = gated.zload;
    assign r0load = gated.rload[0];
    assign r1load = gated.rload[1];
    assign r2load = gated.rload[2];
    assign r3load = gated.rload[3];
    assign r0bus  = gated.rbus[0];
    assign r1bus  = gated.rbus[1];
    assign r2bus  = gated.rbus[2];
    assign r3bus  = gated.rbus[3];
    assign pcbus  = gated.pcbus;
    assign drhbus = gated.drhbus;
    assign drlbus = gated.drlbus;
    assign trbus  = gated.trbus;
    assign ybus   = gated.ybus;
    assign membus = gated.membus;
    assign busmem = gated.busmem;
    assign read   = gated.read;
    assign write  = gated.write;
    assign alus   = gated.alus;
    assign dbg_state = state;

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: directed instruction sequences with hand-written strobe
// expectations queued per cycle, plus a random program under bus/memory invariants.
module tb_cpu_control;
    import cpu_pkg::*;

    localparam int W = 37;

    logic       clk, rst, z;
    logic [7:0] din;
    logic [1:0] cpustate;
    logic       arload, arinc, pcload, pcinc, drload, trload, irload, xload, yload, zload;
    logic       r0load, r1load, r2load, r3load, r0bus, r1bus, r2bus, r3bus;
    logic       pcbus, drhbus, drlbus, trbus, ybus, membus, busmem, read, write, clr;
    logic [3:0] alus;
    state_t     dbg_state;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cycle  = 0;
    logic         cur_rst;
    logic [7:0]   cur_din;
    logic         cur_z;

    localparam logic [27:0] S_ARLOAD = 28'd1 << 0,  S_ARINC  = 28'd1 << 1,  S_PCLOAD = 28'd1 << 2;
    localparam logic [27:0] S_PCINC  = 28'd1 << 3,  S_DRLOAD = 28'd1 << 4,  S_TRLOAD = 28'd1 << 5;
    localparam logic [27:0] S_IRLOAD = 28'd1 << 6,  S_XLOAD  = 28'd1 << 7,  S_YLOAD  = 28'd1 << 8;
    localparam logic [27:0] S_ZLOAD  = 28'd1 << 9,  S_PCBUS  = 28'd1 << 18, S_DRHBUS = 28'd1 << 19;
    localparam logic [27:0] S_DRLBUS = 28'd1 << 20, S_TRBUS  = 28'd1 << 21, S_YBUS   = 28'd1 << 22;
    localparam logic [27:0] S_MEMBUS = 28'd1 << 23, S_BUSMEM = 28'd1 << 24, S_READ   = 28'd1 << 25;
    localparam logic [27:0] S_WRITE  = 28'd1 << 26, S_CLR    = 28'd1 << 27;
    localparam logic [27:0] F1E  = S_PCBUS | S_ARLOAD;
    localparam logic [27:0] F2E  = S_READ | S_MEMBUS | S_DRLOAD | S_PCINC;
    localparam logic [27:0] A2E  = F2E | S_ARINC;
    localparam logic [27:0] A3E  = S_TRLOAD | S_READ | S_MEMBUS | S_DRLOAD | S_PCINC;
    localparam logic [27:0] ADRE = S_DRHBUS | S_TRBUS;

    cpu_control #(.HALT_ON_UNDEF(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .z(z), .cpustate(cpustate),
        .arload(arload), .arinc(arinc), .pcload(pcload), .pcinc(pcinc), .drload(drload),
        .trload(trload), .irload(irload), .xload(xload), .yload(yload), .zload(zload),
        .r0load(r0load), .r1load(r1load), .r2load(r2load), .r3load(r3load),
        .r0bus(r0bus), .r1bus(r1bus), .r2bus(r2bus), .r3bus(r3bus),
        .pcbus(pcbus), .drhbus(drhbus), .drlbus(drlbus), .trbus(trbus), .ybus(ybus),
        .membus(membus), .busmem(busmem), .read(read), .write(write),
        .alus(alus), .clr(clr), .dbg_state(dbg_state)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] rl(input int n);
        return 28'd1 << (10 + n);
    endfunction

    function automatic logic [27:0] rb(input int n);
        return 28'd1 << (14 + n);
    endfunction

    function automatic logic [W-1:0] ex(input state_t s, input logic [3:0] a, input logic [27:0] st);
        return {s, a, st};
    endfunction

    // ---- driver tasks ----
    task automatic step(input logic [1:0] cs, input bit chk, input logic [W-1:0] e);
        @(posedge clk);
        #1;
        rst      = cur_rst;
        cpustate = cs;
        din      = cur_din;
        z        = cur_z;
        if (chk) exp_q.push_back(e);
    endtask

    task automatic cyc(input state_t s, input logic [3:0] a, input logic [27:0] st);
        step(CS_RUN, 1'b1, ex(s, a, st));
    endtask

    // F1..F3 with the old ir on din, then the new instruction is presented in DEC.
    task automatic fetch(input logic [7:0] nxt);
        cyc(ST_F1, ALUS_PASS, F1E);
        cyc(ST_F2, ALUS_PASS, F2E);
        cyc(ST_F3, ALUS_PASS, S_IRLOAD);
        cur_din = nxt;
        cyc(ST_DEC, ALUS_PASS, 28'h0);
    endtask

    task automatic addr_fetch();
        cyc(ST_A1, ALUS_PASS, F1E);
        cyc(ST_A2, ALUS_PASS, A2E);
        cyc(ST_A3, ALUS_PASS, A3E);
    endtask

    // ---- scoreboard / monitor ----
    always @(negedge clk) begin
        logic [W-1:0] obs;
        logic [W-1:0] e;
        int           nbus;
        cycle++;
        obs = {dbg_state, alus, clr, write, read, busmem, membus, ybus, trbus, drlbus, drhbus,
               pcbus, r3bus, r2bus, r1bus, r0bus, r3load, r2load, r1load, r0load,
               zload, yload, xload, irload, trload, drload, pcinc, pcload, arinc, arload};
        nbus = int'(pcbus) + int'(drlbus) + int'(r0bus) + int'(r1bus) + int'(r2bus) +
               int'(r3bus) + int'(ybus) + int'(membus) + int'(drhbus | trbus);
        checks++;
        if (nbus > 1 || drhbus != trbus) begin
            errors++;
            $display("FAIL bus_onehot @cycle %0d: drivers=%0d drhbus=%b trbus=%b, want <=1 and drhbus==trbus",
                     cycle, nbus, drhbus, trbus);
        end
        checks++;
        if (read && write) begin
            errors++;
            $display("FAIL read_write @cycle %0d: read=%b write=%b, want not both", cycle, read, write);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL outputs @cycle %0d: got state=%0d alus=%h strobes=%h, want state=%0d alus=%h strobes=%h",
                         cycle, obs[36:32], obs[31:28], obs[27:0], e[36:32], e[31:28], e[27:0]);
            end
        end
    end

    // ---- stimulus ----
    initial begin
        rst = 1'b0; cpustate = CS_STOP; din = 8'h00; z = 1'b0;
        cur_rst = 1'b0; cur_din = 8'h56; cur_z = 1'b0;

        // Reset: everything quiet even with run or clear requested.
        step(CS_RUN,   1'b1, ex(ST_IDLE, ALUS_PASS, 28'h0));
        step(CS_CLEAR, 1'b1, ex(ST_IDLE, ALUS_PASS, 28'h0));
        cur_rst = 1'b1;
        cyc(ST_IDLE, ALUS_PASS, 28'h0);

        // ADD r1,r2
        fetch(8'h56);
        cyc(ST_X1, ALUS_PASS, rb(1) | S_XLOAD);
        cyc(ST_X2, ALUS_ADD,  rb(2) | S_YLOAD | S_ZLOAD);
        cyc(ST_X3, ALUS_PASS, S_YBUS | rl(1));

        // LDA r0,addr
        fetch(8'h10);
        addr_fetch();
        cyc(ST_L1, ALUS_PASS, ADRE | S_ARLOAD);
        cyc(ST_L2, ALUS_PASS, S_READ | S_MEMBUS | S_DRLOAD);
        cyc(ST_L3, ALUS_PASS, S_DRLBUS | rl(0));

        // STA addr,r3
        fetch(8'h23);
        addr_fetch();
        cyc(ST_S1, ALUS_PASS, ADRE | S_ARLOAD);
        cyc(ST_S2, ALUS_PASS, rb(3) | S_BUSMEM | S_WRITE);

        // MOV r2,r1
        fetch(8'h39);
        cyc(ST_MV, ALUS_PASS, rb(1) | rl(2));

        // MVI r3,imm
        fetch(8'h4C);
        cyc(ST_M1, ALUS_PASS, F1E);
        cyc(ST_M2, ALUS_PASS, F2E);
        cyc(ST_M3, ALUS_PASS, S_DRLBUS | rl(3));

        // SUB r0,r3 under single-step control
        fetch(8'h63);
        step(CS_STEP, 1'b1, ex(ST_X1, ALUS_PASS, rb(0) | S_XLOAD));
        step(CS_STEP, 1'b1, ex(ST_X2, ALUS_SUB,  rb(3) | S_YLOAD | S_ZLOAD));
        step(CS_STEP, 1'b1, ex(ST_X3, ALUS_PASS, S_YBUS | rl(0)));

        // OR r3,r0
        fetch(8'h8C);
        cyc(ST_X1, ALUS_PASS, rb(3) | S_XLOAD);
        cyc(ST_X2, ALUS_OR,   rb(0) | S_YLOAD | S_ZLOAD);
        cyc(ST_X3, ALUS_PASS, S_YBUS | rl(3));

        // NOT r2 and INC r1 skip X1 and drive rd in X2
        fetch(8'h98);
        cyc(ST_X2, ALUS_NOT,  rb(2) | S_YLOAD | S_ZLOAD);
        cyc(ST_X3, ALUS_PASS, S_YBUS | rl(2));
        fetch(8'hA4);
        cyc(ST_X2, ALUS_INC,  rb(1) | S_YLOAD | S_ZLOAD);
        cyc(ST_X3, ALUS_PASS, S_YBUS | rl(1));

        // Conditional jumps, both outcomes; JMP always taken
        fetch(8'hC0); addr_fetch(); cyc(ST_J1, ALUS_PASS, 28'h0);
        cur_z = 1'b1;
        fetch(8'hC0); addr_fetch(); cyc(ST_J1, ALUS_PASS, ADRE | S_PCLOAD);
        fetch(8'hD0); addr_fetch(); cyc(ST_J1, ALUS_PASS, 28'h0);
        cur_z = 1'b0;
        fetch(8'hD0); addr_fetch(); cyc(ST_J1, ALUS_PASS, ADRE | S_PCLOAD);
        cur_z = 1'b1;
        fetch(8'hB0); addr_fetch(); cyc(ST_J1, ALUS_PASS, ADRE | S_PCLOAD);

        // NOP and undefined opcode both return straight to F1
        fetch(8'h00);
        fetch(8'hF0);

        // Stop mid ALU op, then resume in the same state
        fetch(8'h56);
        cyc(ST_X1, ALUS_PASS, rb(1) | S_XLOAD);
        step(CS_STOP, 1'b1, ex(ST_X2, ALUS_PASS, 28'h0));
        step(CS_STOP, 1'b1, ex(ST_X2, ALUS_PASS, 28'h0));
        cyc(ST_X2, ALUS_ADD,  rb(2) | S_YLOAD | S_ZLOAD);
        cyc(ST_X3, ALUS_PASS, S_YBUS | rl(1));

        // Clear mid ALU op
        fetch(8'h75);
        cyc(ST_X1, ALUS_PASS, rb(1) | S_XLOAD);
        step(CS_CLEAR, 1'b1, ex(ST_X2, ALUS_PASS, S_CLR));
        cyc(ST_IDLE, ALUS_PASS, 28'h0);

        // Async reset in the middle of LDA
        fetch(8'h14);
        addr_fetch();
        cyc(ST_L1, ALUS_PASS, ADRE | S_ARLOAD);
        cur_rst = 1'b0;
        cyc(ST_IDLE, ALUS_PASS, 28'h0);
        cyc(ST_IDLE, ALUS_PASS, 28'h0);
        cur_rst = 1'b1;
        cyc(ST_IDLE, ALUS_PASS, 28'h0);

        // HLT holds until clear
        fetch(8'hE0);
        cyc(ST_HALT, ALUS_PASS, 28'h0);
        cyc(ST_HALT, ALUS_PASS, 28'h0);
        cyc(ST_HALT, ALUS_PASS, 28'h0);
        step(CS_CLEAR, 1'b1, ex(ST_HALT, ALUS_PASS, S_CLR));
        cyc(ST_IDLE, ALUS_PASS, 28'h0);

        // Random program: invariants every cycle, HLT hold checked when it appears
        for (int i = 0; i < 400; i++) begin
            cur_z = 1'($urandom_range(0, 1));
            step(CS_RUN, 1'b0, '0);
            if (dbg_state == ST_DEC) begin
                cur_din = 8'($urandom_range(0, 255));
                din     = cur_din;
            end else if (dbg_state == ST_HALT) begin
                cyc(ST_HALT, ALUS_PASS, 28'h0);
                cyc(ST_HALT, ALUS_PASS, 28'h0);
                step(CS_CLEAR, 1'b1, ex(ST_HALT, ALUS_PASS, S_CLR));
                cyc(ST_IDLE, ALUS_PASS, 28'h0);
            end
        end

        step(CS_STOP, 1'b0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
